nixie_scan_ctrl: RTL
====================

Name: nixie_scan_ctrl

Overview:
Scan scheduler and source arbiter for the multiplexed 7-segment display.
- Time-slices the display across DIGITS digit positions. Each slot opens with an anti-ghosting blank interval.
- Arbitrates the display between a background source (Bg) and a priority requester (Pri). The source can only change on a frame boundary, so frames never tear.
- Drives COM/SEG directly and sits between the key/counter logic and the board pins.

Parameters:
- DIGITS, 2, number of digit positions (2..8).
- CLK_DIV, 5000, Sys_CLK cycles per digit slot (>=4).
- BLANK_CYC, 16, cycles at the start of each slot with COM all-off (1..CLK_DIV-2).

Ports:
- Sys_CLK, input, 1, system clock.
- Sys_RST, input, 1, asynchronous active-high reset.
- EN, input, 1, display enable.
- Bg_Data, input, 4*DIGITS, background hex nibbles; nibble i drives digit i (digit 0 = bits 3:0).
- Pri_Req, input, 1, priority requester wants the display.
- Pri_Data, input, 4*DIGITS, priority hex nibbles, same layout as Bg_Data.
- Pri_Grant, output, 1, the current frame shows Pri_Data.
- COM, output, DIGITS, one-hot digit select, active-high (digit0 = 'b..01).
- SEG, output, 8, segments {a,b,c,d,e,f,g,dp}, active-high, dp always 0.
- Frame_Start, output, 1, one-cycle pulse on the cycle the frame buffer loads.

Behaviour:
Clocking and reset:
- Single clock domain, Sys_CLK.
- Sys_RST asynchronously forces: state=IDLE, prescaler=0, digit=0, frame buffer=0, COM=0, SEG=0, Pri_Grant=0, Frame_Start=0.
- A reset mid-slot takes effect immediately. No glitch pulse is allowed on COM.
- All outputs are registered.

State machine (IDLE, BLANK, DRIVE):
- IDLE: COM=0, SEG=0, prescaler held at 0. When EN=1, perform a frame load and go to BLANK.
- Frame load happens on one clock edge:
  - buffer <= Pri_Req ? Pri_Data : Bg_Data
  - Pri_Grant <= Pri_Req
  - digit <= 0, prescaler <= 0
  - Frame_Start pulses for one cycle
  - SEG <= decode(the nibble being loaded for digit 0)
- BLANK: COM=0 for BLANK_CYC cycles (prescaler 0..BLANK_CYC-1), then go to DRIVE.
- DRIVE: COM[digit]=1 while the prescaler runs BLANK_CYC..CLK_DIV-1. At prescaler=CLK_DIV-1:
  - If digit<DIGITS-1: digit++, prescaler=0, SEG <= decode(buffer nibble digit+1), go to BLANK.
  - If digit=DIGITS-1: frame load (frame boundary), go to BLANK.
- EN=0 in any state: go to IDLE on the next edge; COM=0 and SEG=0 from that edge. Pri_Grant holds its value.

Timing and arbitration rules:
- SEG changes only on the edge that enters BLANK, so SEG is stable for BLANK_CYC cycles before COM rises.
- COM is never asserted for more than one digit in any cycle.
- Slot length is exactly CLK_DIV cycles; frame length is exactly DIGITS*CLK_DIV cycles.
- Pri_Req is sampled only at frame loads. Latency from Pri_Req rising to Pri_Grant is 1 to DIGITS*CLK_DIV cycles. Release behaves the same way.
- Pri_Data/Bg_Data changes mid-frame are ignored until the next load.
- Hex decode (SEG[7:0]): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E.

Optional Feature:
- LEAD_ZERO_BLANK_EN defined: at frame load, compute a per-digit suppress mask. Digit i (i>0) is suppressed when its nibble and all higher nibbles are 0. A suppressed digit keeps COM=0 for its whole slot, but slot timing is unchanged. Digit 0 is never suppressed.
- Undefined: all digits are always driven.

Decomposition:
- Shared package nixie_pkg:
  - state enum {IDLE, BLANK, DRIVE}
  - SEG code constants SEG_0..SEG_F
  - function/localparam for the prescaler width, $clog2(CLK_DIV)
- One sub-module, nixie_hex_decode: combinational 4-bit nibble to 8-bit SEG code, instantiated once on the nibble selected for the next slot.

Test Plan (DIGITS=2, CLK_DIV=10, BLANK_CYC=2):
1. Bg_Data=8'h3A, Pri_Req=0, EN 0->1.
   - Frame_Start pulses; SEG=EE.
   - COM=00 for 2 cycles, then 01 for 8; then SEG=F2, COM=00 for 2, then 10 for 8.
   - Period is 20 cycles; Pri_Grant=0 throughout.
2. Pri_Data=8'h55, Pri_Req raised 3 cycles into a frame.
   - The remainder of the frame shows 3,A.
   - Pri_Grant rises at the frame load; the next frame shows SEG=B6 on both digits.
3. Pri_Req dropped mid-frame.
   - The frame completes showing 5,5.
   - Pri_Grant falls at the next load; display returns to Bg_Data.
4. Sys_RST pulsed asynchronously mid-DRIVE.
   - COM=00, SEG=00, Pri_Grant=0 without waiting for a clock edge.
   - After release with EN=1, restart at digit 0 BLANK with Frame_Start.
5. EN dropped during digit 1 DRIVE.
   - COM=00 and SEG=00 on the next edge.
   - EN re-raised: fresh frame load, digit 0 first.
6. LEAD_ZERO_BLANK_EN defined.
   - Bg_Data=8'h07: digit 1 slot keeps COM=00; digit 0 shows E0.
   - Bg_Data=8'h00: digit 0 shows FC.
   - Bg_Data=8'h70: both digits driven.

Source files
------------

// File: rtl/nixie_pkg.sv
// -----------------------------------------------------------------------------
// nixie_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   - scan_state_t : scan FSM states (IDLE, BLANK, DRIVE)
//   - SEG_0..SEG_F : active-high segment codes {a,b,c,d,e,f,g,dp}, dp = 0
//   - presc_width(): prescaler counter width for a given slot length
// -----------------------------------------------------------------------------
package nixie_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Width of a counter that holds 0..clk_div-1.
    function automatic int presc_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/nixie_hex_decode.sv
// -----------------------------------------------------------------------------
// nixie_hex_decode
// Combinational hex nibble to 7-segment code (active-high, dp always 0).
// Ports:
//   nibble : input  [3:0] hex value
//   seg    : output [7:0] {a,b,c,d,e,f,g,dp}
// -----------------------------------------------------------------------------
module nixie_hex_decode
    import nixie_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        seg = SEG_0;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// -----------------------------------------------------------------------------
// nixie_scan_ctrl
// Scan scheduler and source arbiter for a multiplexed 7-segment display.
// Each digit slot is CLK_DIV cycles: BLANK_CYC cycles with COM all-off
// (anti-ghosting, SEG already settled), then COM drives the digit. The frame
// buffer and the Bg/Pri source choice are latched only at frame loads, so a
// frame never tears.
//
// Ports:
//   Sys_CLK     : system clock
//   Sys_RST     : asynchronous active-high reset
//   EN          : display enable (0 -> IDLE, outputs blank)
//   Bg_Data     : background nibbles, digit i = bits 4i+3:4i
//   Pri_Req     : priority requester wants the display (sampled at loads)
//   Pri_Data    : priority nibbles, same layout as Bg_Data
//   Pri_Grant   : current frame shows Pri_Data
//   COM         : one-hot active-high digit select
//   SEG         : {a,b,c,d,e,f,g,dp}, active-high
//   Frame_Start : one-cycle pulse on the cycle after a frame load
//
// Build option: define LEAD_ZERO_BLANK_EN to suppress leading-zero digits
// (digit i>0 whose nibble and all higher nibbles are 0 keeps COM off for its
// slot; slot timing is unchanged).
// -----------------------------------------------------------------------------
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int CLK_DIV   = 5000,
    parameter int BLANK_CYC = 16
)(
    input  logic                  Sys_CLK,
    input  logic                  Sys_RST,
    input  logic                  EN,
    input  logic [4*DIGITS-1:0]   Bg_Data,
    input  logic                  Pri_Req,
    input  logic [4*DIGITS-1:0]   Pri_Data,
    output logic                  Pri_Grant,
    output logic [DIGITS-1:0]     COM,
    output logic [7:0]            SEG,
    output logic                  Frame_Start
);

    localparam int PW = presc_width(CLK_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    scan_state_t          state_q,  state_d;
    logic [PW-1:0]        presc_q,  presc_d;
    logic [DW-1:0]        digit_q,  digit_d;
    logic [4*DIGITS-1:0]  buf_q,    buf_d;
    logic [DIGITS-1:0]    com_q,    com_d;
    logic [7:0]           seg_q,    seg_d;
    logic                 grant_q,  grant_d;
    logic                 fs_q,     fs_d;

    logic [4*DIGITS-1:0]  load_src;
    logic                 slot_end;
    logic                 load_now;
    logic [DW-1:0]        digit_inc;
    logic [3:0]           dec_nibble;
    logic [7:0]           dec_seg;
    logic [DIGITS-1:0]    supp_q;

    assign load_src = Pri_Req ? Pri_Data : Bg_Data;
    assign slot_end = (presc_q == PRESC_LAST);

    // A frame load happens when the display starts from IDLE or when the last
    // digit's slot expires.
    assign load_now = EN && ((state_q == IDLE) ||
                             (state_q == DRIVE && slot_end && digit_q == DIGIT_LAST));

    assign digit_inc = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);

    // Single decoder shared by both SEG update points: the first digit of a
    // freshly loaded frame, or the next digit of the current buffer.
    always_comb begin
        dec_nibble = load_src[3:0];
        if (!load_now) begin
            dec_nibble = buf_q[4*int'(digit_inc) +: 4];
        end
    end

    nixie_hex_decode u_hex_decode (
        .nibble (dec_nibble),
        .seg    (dec_seg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0] supp_load;

    // Walk from the most significant digit down; a digit is suppressed while
    // every nibble from it upwards is zero. Digit 0 is never suppressed.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        supp_load = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero     = all_zero && (load_src[4*i +: 4] == 4'h0);
            supp_load[i] = all_zero;
        end
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            supp_q <= '0;
        end else if (load_now) begin
            supp_q <= supp_load;
        end
    end
`else
    assign supp_q = '0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        digit_d = digit_q;
        buf_d   = buf_q;
        seg_d   = seg_q;
        grant_d = grant_q;
        fs_d    = 1'b0;
        com_d   = '0;

        if (!EN) begin
            state_d = IDLE;
            presc_d = '0;
            digit_d = '0;
            seg_d   = '0;
        end else if (load_now) begin
            state_d = BLANK;
            presc_d = '0;
            digit_d = '0;
            buf_d   = load_src;
            grant_d = Pri_Req;
            seg_d   = dec_seg;
            fs_d    = 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (presc_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end
                    presc_d = presc_q + PW'(1);
                end
                DRIVE: begin
                    if (slot_end) begin
                        state_d = BLANK;
                        presc_d = '0;
                        digit_d = digit_inc;
                        seg_d   = dec_seg;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        // COM is derived from the next state so it is registered like every
        // other output and can only ever select the one digit being driven.
        if (state_d == DRIVE && !supp_q[digit_d]) begin
            com_d = DIGITS'(1) << digit_d;
        end
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state_q <= IDLE;
            presc_q <= '0;
            digit_q <= '0;
            buf_q   <= '0;
            com_q   <= '0;
            seg_q   <= '0;
            grant_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of ordering.
            state_q <= state_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            buf_q   <= buf_d;
            com_q   <= com_d;
            seg_q   <= seg_d;
            grant_q <= grant_d;
            fs_q    <= fs_d;
        end
    end

    assign Pri_Grant   = grant_q;
    assign COM         = com_q;
    assign SEG         = seg_q;
    assign Frame_Start = fs_q;

endmodule
